// File: rtl/bitserial_datapath.sv
// ---------------------------------------------------------------------------
// bitserial_datapath
//
// Bit-serial execution datapath driven one cycle at a time by the instruction
// decoder. Holds the general-purpose register (GPR) and accumulator (ACC) as
// LSB-first shift registers, a 1-bit serial ALU with a carry flop, switch bit
// selection, and a registered add-result / overflow capture for the display.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset
//   i_sw             switch word, one bit sampled per cycle
//   i_con_mux8       index of the switch bit to sample
//   i_con_mux        GPR serial-input source: 1 = switch bit, 0 = ALU bit
//   i_con_muxalu     ALU mode: 1 = transfer, 0 = serial add
//   i_con_gpr_shift  shift GPR right by one
//   i_con_gpr_write  on a GPR shift load the selected bit, else rotate
//   i_con_acc_shift  shift ACC right by one
//   i_con_acc_write  on an ACC shift load the ALU bit, else rotate
//   i_con_pcincr     instruction-boundary strobe
//   o_gpr / o_acc    current register contents
//   o_result         last completed add result
//   o_ovf            carry-out of the last completed add
//   o_done           one-cycle pulse following a result capture
//   o_bitpos         shift cycles since the last boundary, modulo 8
// ---------------------------------------------------------------------------
module bitserial_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sw,
    input  logic [2:0]       i_con_mux8,
    input  logic             i_con_mux,
    input  logic             i_con_muxalu,
    input  logic             i_con_gpr_shift,
    input  logic             i_con_gpr_write,
    input  logic             i_con_acc_shift,
    input  logic             i_con_acc_write,
    input  logic             i_con_pcincr,
    output logic [WIDTH-1:0] o_gpr,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
    output logic             o_done,
    output logic [2:0]       o_bitpos
);

    logic [WIDTH-1:0] gpr_q, gpr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [2:0]       bitpos_q, bitpos_d;

    logic alu_bit;
    logic cout;
    logic gpr_din;
    logic add_capture;

    // Serial ALU works on the pre-edge LSBs of both registers, so a
    // simultaneous GPR and ACC shift sees consistent operands.
    assign alu_bit = i_con_muxalu ? gpr_q[0] : (gpr_q[0] ^ acc_q[0] ^ carry_q);
    assign cout    = (gpr_q[0] & acc_q[0]) | (gpr_q[0] & carry_q) | (acc_q[0] & carry_q);
    assign gpr_din = i_con_mux ? i_sw[i_con_mux8] : alu_bit;

    // Last bit of a serial add writing back into the GPR.
    assign add_capture = i_con_pcincr & i_con_gpr_shift & i_con_gpr_write
                       & ~i_con_mux & ~i_con_muxalu;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        gpr_d    = gpr_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        bitpos_d = bitpos_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        if (i_con_gpr_shift) begin
            gpr_d = {(i_con_gpr_write ? gpr_din : gpr_q[0]), gpr_q[WIDTH-1:1]};
        end

        if (i_con_acc_shift) begin
            acc_d = {(i_con_acc_write ? alu_bit : acc_q[0]), acc_q[WIDTH-1:1]};
        end

        // Boundary clears carry; transfer mode never touches it.
        if (i_con_pcincr) begin
            carry_d = 1'b0;
        end else if (!i_con_muxalu && i_con_gpr_shift && i_con_acc_shift) begin
            carry_d = cout;
        end

        // 3-bit counter wraps 7 -> 0 naturally.
        if (i_con_pcincr) begin
            bitpos_d = 3'd0;
        end else if (i_con_gpr_shift || i_con_acc_shift) begin
            bitpos_d = bitpos_q + 3'd1;
        end

        if (add_capture) begin
            result_d = {alu_bit, gpr_q[WIDTH-1:1]};
            ovf_d    = cout;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            gpr_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            bitpos_q <= 3'd0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            gpr_q    <= gpr_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            bitpos_q <= bitpos_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign o_gpr    = gpr_q;
    assign o_acc    = acc_q;
    assign o_result = result_q;
    assign o_ovf    = ovf_q;
    assign o_done   = done_q;
    assign o_bitpos = bitpos_q;

endmodule

// File: tb/tb_bitserial_datapath.sv
// ---------------------------------------------------------------------------
// tb_bitserial_datapath
//
// Directed stimulus for bitserial_datapath. An integer-level reference model
// tracks register values as plain numbers and is compared against every DUT
// output on each falling edge; literal expectations pin the model at the end
// of each operation (load, transfer, add, overflow, reset mid-add, rotate).
// ---------------------------------------------------------------------------
module tb_bitserial_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic [2:0] mux8;
    logic       mux, muxalu, gs, gw, acs, acw, pc;

    logic [7:0] gpr, acc, result;
    logic       ovf, done;
    logic [2:0] bitpos;

    always #5 clk = ~clk;

    bitserial_datapath #(.WIDTH(8)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_sw            (sw),
        .i_con_mux8      (mux8),
        .i_con_mux       (mux),
        .i_con_muxalu    (muxalu),
        .i_con_gpr_shift (gs),
        .i_con_gpr_write (gw),
        .i_con_acc_shift (acs),
        .i_con_acc_write (acw),
        .i_con_pcincr    (pc),
        .o_gpr           (gpr),
        .o_acc           (acc),
        .o_result        (result),
        .o_ovf           (ovf),
        .o_done          (done),
        .o_bitpos        (bitpos)
    );

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as integers, add as integer sum of bits.
    int m_gpr, m_acc, m_carry, m_pos, m_res, m_ovf, m_done;

    always @(posedge clk) begin : model
        int g0, a0, s, alu, co, din, new_gpr, new_acc;
        if (rst) begin
            m_gpr = 0; m_acc = 0; m_carry = 0; m_pos = 0;
            m_res = 0; m_ovf = 0; m_done = 0;
        end else begin
            g0  = m_gpr % 2;
            a0  = m_acc % 2;
            s   = g0 + a0 + m_carry;
            alu = muxalu ? g0 : s % 2;
            co  = s / 2;
            din = mux ? ((int'(sw) >> mux8) % 2) : alu;

            new_gpr = m_gpr;
            new_acc = m_acc;
            if (gs)  new_gpr = (m_gpr / 2) + 128 * (gw ? din : g0);
            if (acs) new_acc = (m_acc / 2) + 128 * (acw ? alu : a0);

            if (pc && gs && gw && !mux && !muxalu) begin
                m_res  = new_gpr;
                m_ovf  = co;
                m_done = 1;
            end else begin
                m_done = 0;
            end

            if (pc) m_carry = 0;
            else if (!muxalu && gs && acs) m_carry = co;

            if (pc) m_pos = 0;
            else if (gs || acs) m_pos = (m_pos + 1) % 8;

            m_gpr = new_gpr;
            m_acc = new_acc;
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("gpr",    32'(gpr),    m_gpr);
            check("acc",    32'(acc),    m_acc);
            check("result", 32'(result), m_res);
            check("ovf",    32'(ovf),    m_ovf);
            check("done",   32'(done),   m_done);
            check("bitpos", 32'(bitpos), m_pos);
        end
    end

    // Apply one control word for one clock; returns on the next falling edge.
    task automatic drive(input logic r, input logic m, input logic ma,
                         input logic g_s, input logic g_w,
                         input logic a_s, input logic a_w, input logic p,
                         input logic [2:0] sel, input logic [7:0] s);
        rst = r; mux = m; muxalu = ma; gs = g_s; gw = g_w;
        acs = a_s; acw = a_w; pc = p; mux8 = sel; sw = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'($urandom));
    endtask

    task automatic nop_pc();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 8'($urandom));
    endtask

    // Load GPR from switches; non-selected switch bits are scrambled.
    task automatic load(input logic [7:0] val);
        logic [7:0] s;
        for (int k = 0; k < 8; k++) begin
            s = 8'($urandom);
            s[k] = val[k];
            drive(0, 1, 0, 1, 1, 0, 0, 0, 3'(k), s);
        end
    endtask

    task automatic transfer();
        for (int k = 0; k < 8; k++) drive(0, 0, 1, 1, 1, 1, 1, 0, 3'd0, 8'($urandom));
    endtask

    // Serial add into GPR; ACC rotates. stop_at < 8 asserts reset on that cycle.
    task automatic add(input int stop_at);
        for (int k = 0; k < 8; k++) begin
            if (k == stop_at) begin
                drive(1, 0, 0, 1, 1, 1, 0, 0, 3'd0, 8'($urandom));
                return;
            end
            drive(0, 0, 0, 1, 1, 1, 0, (k == 7), 3'd0, 8'($urandom));
        end
    endtask

    task automatic rotate(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'($urandom));
    endtask

    initial begin
        rst = 1; mux = 0; muxalu = 0; gs = 0; gw = 0;
        acs = 0; acw = 0; pc = 0; mux8 = 0; sw = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        chk_en = 1'b1;

        // Reset state
        check("rst_gpr",    32'(gpr),    0);
        check("rst_acc",    32'(acc),    0);
        check("rst_result", 32'(result), 0);
        check("rst_done",   32'(done),   0);

        // Load 0x5A from switches
        load(8'h5A);
        check("load_gpr",    32'(gpr),    8'h5A);
        check("load_acc",    32'(acc),    0);
        check("load_bitpos", 32'(bitpos), 0);

        // Transfer GPR to ACC
        transfer();
        check("xfer_acc", 32'(acc), 8'h5A);
        check("xfer_gpr", 32'(gpr), 8'h5A);

        // Idle holds everything
        idle(4);
        check("hold_gpr", 32'(gpr), 8'h5A);
        check("hold_acc", 32'(acc), 8'h5A);

        // Add without overflow: 0x5A + 0x23
        load(8'h23);
        transfer();
        load(8'h5A);
        nop_pc();
        add(8);
        check("add_gpr",    32'(gpr),    8'h7D);
        check("add_acc",    32'(acc),    8'h23);
        check("add_result", 32'(result), 8'h7D);
        check("add_ovf",    32'(ovf),    0);
        check("add_done",   32'(done),   1);
        idle(1);
        check("add_done_end", 32'(done), 0);

        // Add with overflow: 0xF0 + 0x20
        load(8'h20);
        transfer();
        load(8'hF0);
        nop_pc();
        add(8);
        check("ovf_result", 32'(result), 8'h10);
        check("ovf_ovf",    32'(ovf),    1);
        check("ovf_done",   32'(done),   1);
        nop_pc();
        check("nop_result", 32'(result), 8'h10);
        check("nop_ovf",    32'(ovf),    1);
        check("nop_done",   32'(done),   0);
        check("nop_bitpos", 32'(bitpos), 0);

        // Reset on cycle 4 of an add of 0xFF + 0xFF (carry active)
        load(8'hFF);
        transfer();
        nop_pc();
        add(3);
        check("mrst_gpr",    32'(gpr),    0);
        check("mrst_acc",    32'(acc),    0);
        check("mrst_result", 32'(result), 0);
        check("mrst_ovf",    32'(ovf),    0);
        check("mrst_done",   32'(done),   0);
        check("mrst_bitpos", 32'(bitpos), 0);
        idle(2);
        check("mrst_done2", 32'(done), 0);

        // 0x01 + 0x01 after reset: no stale carry
        load(8'h01);
        transfer();
        add(8);
        check("post_result", 32'(result), 8'h02);
        check("post_ovf",    32'(ovf),    0);

        // Rotate-only on 0xC3
        load(8'hC3);
        rotate(3);
        check("rot3_gpr",    32'(gpr),    8'h78);
        check("rot3_bitpos", 32'(bitpos), 3);
        rotate(5);
        check("rot8_gpr",    32'(gpr),    8'hC3);
        check("rot8_bitpos", 32'(bitpos), 0);

        idle(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
